pwm_dir_rx: RTL and testbench
=============================

PWM_DIR_RX -- requirements
Module: pwm_dir_rx

Interface
REQ-001 Parameter NOM_PERIOD, default 606: nominal PWM frame length in clk cycles.
REQ-002 Parameter PERIOD_TOL, default 6: allowed +/- deviation of the measured frame length.
REQ-003 Parameter MIN_HIGH, default 229: minimum accepted high width in cycles.
REQ-004 Parameter MAX_HIGH, default 371: maximum accepted high width in cycles.
REQ-005 Parameter TIMEOUT, default 1023: cycles without a rising edge before the signal is declared lost.
REQ-006 Port clk, input, 1: system clock, all logic on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port pwm_in, input, 1: asynchronous PWM line from the direction-PWM transmitter.
REQ-009 Port data_out, output, 8: last decoded direction value, held between frames.
REQ-010 Port data_valid, output, 1: one-cycle pulse when data_out is updated.
REQ-011 Port frame_err, output, 1: one-cycle pulse when a completed frame fails a width or period check.
REQ-012 Port signal_lost, output, 1: level, high while no valid frame is being received.

Function
REQ-013 The block SHALL pass pwm_in through a 2-flop synchronizer, then a third flop used for edge detection; all measurements SHALL use the synchronized signal.
REQ-014 The FSM SHALL have states SYNC, HIGH and LOW.
- SYNC: wait for a rising edge; partial frames are discarded.
- SYNC -> HIGH on a rising edge.
- HIGH -> LOW on a falling edge.
- LOW -> HIGH on a rising edge, which closes the frame.
REQ-015 The high count SHALL equal the number of cycles the synchronized signal is 1, counted from and including the rising-edge cycle.
REQ-016 The period count SHALL equal the number of cycles from one rising-edge cycle up to, but excluding, the next rising-edge cycle.
REQ-017 Both counters SHALL be 10 bits, SHALL saturate at 1023, and SHALL clear on each rising edge.
REQ-018 At a closing rising edge, the frame SHALL be valid iff both conditions hold:
- MIN_HIGH <= high count <= MAX_HIGH;
- NOM_PERIOD-PERIOD_TOL <= period count <= NOM_PERIOD+PERIOD_TOL.
REQ-019 On a valid frame:
- data_out SHALL become high count >> 1, truncated to 8 bits;
- data_valid SHALL pulse for one cycle;
- signal_lost SHALL clear.
All three SHALL be registered on the cycle after the closing edge is detected, which is 3 clk cycles after pwm_in rises.
REQ-020 On an invalid frame:
- frame_err SHALL pulse for one cycle with the same timing as data_valid;
- data_out and signal_lost SHALL be unchanged;
- the FSM SHALL stay in HIGH and start measuring the new frame.
REQ-021 data_valid and frame_err SHALL never be asserted in the same cycle.
REQ-022 In HIGH or LOW, when the period count reaches TIMEOUT, the block SHALL:
- set signal_lost to 1;
- return to SYNC;
- hold data_out;
- not pulse frame_err.
REQ-023 When a timeout and a rising edge occur in the same cycle, the timeout SHALL take priority and the edge SHALL be ignored.
REQ-024 A constant-high or constant-low pwm_in SHALL produce the timeout behaviour of REQ-022.
REQ-025 The first rising edge after reset or timeout SHALL only open a frame; no output pulse is produced until the following rising edge.

Reset
REQ-026 On rst, the block SHALL set:
- FSM to SYNC;
- synchronizer flops and counters to 0;
- data_out to 8'd150 (neutral direction);
- data_valid and frame_err to 0;
- signal_lost to 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulse; measurement SHALL resume per REQ-025 after release.

Structure
REQ-028 A shared package pwm_pkg SHALL hold the frame constants (606, 229, 371, neutral 150) used by both the transmitter and this receiver, plus the FSM state enum.
REQ-029 The synchronizer and edge detector SHALL be a sub-module pwm_sync with outputs sync_level, rise and fall.

Verification
REQ-030 Reset, then 3 frames of period 606 with high 300 -> after reset data_out=150 and signal_lost=1; frame 1 opens only; data_valid pulses twice with data_out=150; signal_lost=0 after the first pulse.
REQ-031 Periods of 606 with high widths 230 then 370 -> data_out=115 then 185, each with one data_valid pulse.
REQ-032 Period 606 with high 228 (and separately 372) -> frame_err pulses once, data_out unchanged; a following high-300 frame gives data_valid with data_out=150.
REQ-033 High 300 with period 590 (and separately 620) -> frame_err pulses and no data_valid; period 600 and period 612 are both accepted.
REQ-034 pwm_in held high for 1100 cycles after a valid frame -> signal_lost rises when the period count reaches 1023, data_out is held, no frame_err; subsequent valid frames recover per REQ-025.
REQ-035 rst asserted for 2 cycles during HIGH of a frame -> all outputs return to reset values, no pulse for that frame, and the next two valid frames produce one data_valid.

Source files
------------

// File: rtl/pwm_pkg.sv
// Constants shared by the direction-PWM transmitter and receiver, plus the
// receiver's frame-tracking state encoding.
package pwm_pkg;

   localparam int         PWM_NOM_PERIOD  = 606;
   localparam int         PWM_MIN_HIGH    = 229;
   localparam int         PWM_MAX_HIGH    = 371;
   localparam logic [7:0] PWM_NEUTRAL_DIR = 8'd150;

   localparam int         CNT_W   = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      SYNC,
      HIGH,
      LOW
   } pwm_state_t;

   // The transmitter encodes direction d as a high width of 2*d cycles.
   function automatic logic [7:0] dir_from_high(input logic [CNT_W-1:0] high_cnt);
      return high_cnt[8:1];
   endfunction

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for the asynchronous PWM line, plus a third flop
// that provides single-cycle rise/fall strobes on the synchronized level.
module pwm_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the chain into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= async_in;
         sync <= meta;
         prev <= sync;
      end
   end

   assign sync_level = sync;
   assign rise       = sync & ~prev;
   assign fall       = ~sync & prev;

endmodule

// File: rtl/pwm_dir_rx.sv
// Direction-PWM receiver: measures high width and frame period of each
// frame, validates both, and publishes high/2 as the direction value.
module pwm_dir_rx
   import pwm_pkg::*;
#(
   parameter int NOM_PERIOD = PWM_NOM_PERIOD,
   parameter int PERIOD_TOL = 6,
   parameter int MIN_HIGH   = PWM_MIN_HIGH,
   parameter int MAX_HIGH   = PWM_MAX_HIGH,
   parameter int TIMEOUT    = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       signal_lost
);

   localparam logic [CNT_W-1:0] PERIOD_LO   = CNT_W'(NOM_PERIOD - PERIOD_TOL);
   localparam logic [CNT_W-1:0] PERIOD_HI   = CNT_W'(NOM_PERIOD + PERIOD_TOL);
   localparam logic [CNT_W-1:0] HIGH_LO     = CNT_W'(MIN_HIGH);
   localparam logic [CNT_W-1:0] HIGH_HI     = CNT_W'(MAX_HIGH);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   logic sync_level;
   logic rise;
   logic fall;

   pwm_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .async_in   (pwm_in),
      .sync_level (sync_level),
      .rise       (rise),
      .fall       (fall)
   );

   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;

   // Loading 1 on the rise cycle counts that cycle, so at the next rise the
   // registers hold exactly the period and the high width of the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt <= '0;
         high_cnt   <= '0;
      end else if (rise) begin
         period_cnt <= CNT_W'(1);
         high_cnt   <= CNT_W'(1);
      end else begin
         if (period_cnt != CNT_MAX) period_cnt <= period_cnt + 1'b1;
         if (sync_level && high_cnt != CNT_MAX) high_cnt <= high_cnt + 1'b1;
      end
   end

   pwm_state_t state;
   pwm_state_t state_nxt;
   logic       frame_done;
   logic       frame_good;
   logic       lost_set;
   logic       timed_out;
   logic       in_limits;

   assign timed_out = (period_cnt >= TIMEOUT_CNT);
   assign in_limits = (high_cnt >= HIGH_LO) && (high_cnt <= HIGH_HI) &&
                      (period_cnt >= PERIOD_LO) && (period_cnt <= PERIOD_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SYNC;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      frame_good = 1'b0;
      lost_set   = 1'b0;
      unique case (state)
         SYNC: begin
            if (rise) state_nxt = HIGH;
         end
         HIGH: begin
            if (timed_out) begin
               state_nxt = SYNC;
               lost_set  = 1'b1;
            end else if (fall) begin
               state_nxt = LOW;
            end
         end
         LOW: begin
            if (timed_out) begin
               state_nxt = SYNC;
               lost_set  = 1'b1;
            end else if (rise) begin
               state_nxt  = HIGH;
               frame_done = 1'b1;
               frame_good = in_limits;
            end
         end
         default: state_nxt = SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out    <= PWM_NEUTRAL_DIR;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         data_valid <= frame_done & frame_good;
         frame_err  <= frame_done & ~frame_good;
         if (frame_done && frame_good) begin
            data_out    <= dir_from_high(high_cnt);
            signal_lost <= 1'b0;
         end else if (lost_set) begin
            signal_lost <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_dir_rx.sv
// Scoreboard bench for pwm_dir_rx: stimulus queues the hand-computed pulse
// each closing rise should produce; a monitor checks every output pulse.
module tb_pwm_dir_rx;

   typedef enum logic [1:0] {EV_NONE, EV_VALID, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       pwm_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       signal_lost;

   int  checks = 0;
   int  fails  = 0;
   ev_t exp_q[$];

   always #5 clk = ~clk;

   pwm_dir_rx dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_err   (frame_err),
      .signal_lost (signal_lost)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      ev_t e;
      if (!rst && (data_valid || frame_err)) begin
         check("pulse_exclusive", 32'(data_valid & frame_err), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'({data_valid, frame_err}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", data_valid ? 32'(EV_VALID) : 32'(EV_ERR), 32'(e.kind));
            check("pulse_data_out", 32'(data_out), 32'(e.data));
            if (data_valid) check("lost_after_valid", 32'(signal_lost), 32'd0);
         end
      end
   end

   task automatic drive(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   // k/d: the pulse expected from this frame's rising edge (it closes the
   // previous frame), with the data_out value visible during that pulse.
   task automatic frame(input int h, input int p, input ev_kind_t k, input logic [7:0] d);
      ev_t e;
      if (k != EV_NONE) begin
         e.kind = k;
         e.data = d;
         exp_q.push_back(e);
      end
      drive(1'b1, h);
      drive(1'b0, p - h);
   endtask

   initial begin
      ev_t e;
      int  budget;
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'd150);
      check("rst_signal_lost", 32'(signal_lost), 32'd1);
      check("rst_data_valid", 32'(data_valid), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      drive(1'b0, 20);
      check("idle_signal_lost", 32'(signal_lost), 32'd1);

      // Nominal frames: first rise only opens a frame.
      frame(300, 606, EV_NONE,  8'd0);
      check("open_only_lost", 32'(signal_lost), 32'd1);
      frame(300, 606, EV_VALID, 8'd150);
      check("lost_cleared", 32'(signal_lost), 32'd0);
      frame(300, 606, EV_VALID, 8'd150);

      // High-width limits.
      frame(230, 606, EV_VALID, 8'd150);
      frame(370, 606, EV_VALID, 8'd115);
      frame(228, 606, EV_VALID, 8'd185);
      frame(372, 606, EV_ERR,   8'd185);
      frame(300, 606, EV_ERR,   8'd185);
      frame(300, 606, EV_VALID, 8'd150);

      // Period limits.
      frame(300, 590, EV_VALID, 8'd150);
      frame(300, 620, EV_ERR,   8'd150);
      frame(300, 600, EV_ERR,   8'd150);
      frame(300, 612, EV_VALID, 8'd150);
      frame(240, 606, EV_VALID, 8'd150);

      // Stuck-high line after a valid 240 frame.
      e.kind = EV_VALID;
      e.data = 8'd120;
      exp_q.push_back(e);
      drive(1'b1, 1000);
      check("stuck_lost_early", 32'(signal_lost), 32'd0);
      drive(1'b1, 100);
      check("stuck_lost_set", 32'(signal_lost), 32'd1);
      check("stuck_data_held", 32'(data_out), 32'd120);
      drive(1'b0, 50);
      frame(300, 606, EV_NONE,  8'd0);
      check("recover_open_lost", 32'(signal_lost), 32'd1);
      frame(240, 606, EV_VALID, 8'd150);
      check("recover_lost", 32'(signal_lost), 32'd0);

      // Reset during the high phase of a frame.
      e.kind = EV_VALID;
      e.data = 8'd120;
      exp_q.push_back(e);
      drive(1'b1, 100);
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_data_out", 32'(data_out), 32'd150);
      check("midrst_lost", 32'(signal_lost), 32'd1);
      check("midrst_valid", 32'(data_valid), 32'd0);
      rst = 1'b0;
      drive(1'b0, 200);
      frame(300, 606, EV_NONE,  8'd0);
      frame(300, 606, EV_VALID, 8'd150);
      drive(1'b0, 50);

      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
